// File: rtl/soc_bus_fabric_pkg.sv
// Shared definitions for the SoC bus fabric: wait-state FSM encoding,
// read-source selection and control-page register map.
package soc_bus_fabric_pkg;

  typedef enum logic [1:0] {
    FSM_IDLE    = 2'd0,
    FSM_WAIT    = 2'd1,
    FSM_STRETCH = 2'd2,
    FSM_DONE    = 2'd3
  } fsm_state_e;

  typedef enum logic [2:0] {
    SRC_UNMAPPED = 3'd0,
    SRC_RAM      = 3'd1,
    SRC_ROM      = 3'd2,
    SRC_SLOT     = 3'd3,
    SRC_CTRL     = 3'd4
  } src_e;

  localparam logic [5:0] CTRL_SUBPAGE = 6'd63;

  localparam logic [5:0] REG_STATUS = 6'd0;
  localparam logic [5:0] REG_MASK   = 6'd1;
  localparam logic [5:0] REG_ERR    = 6'd2;

  localparam logic [7:0] UNMAPPED_RD = 8'hFF;

  // Layout of the ERR register as seen by the CPU.
  function automatic logic [7:0] err_reg_value(input logic err, input logic [2:0] slot);
    return {err, 4'b0000, slot};
  endfunction

endpackage

// File: rtl/soc_bus_waitgen.sv
// Slot-access wait/stretch sequencer: fixed wait cycles, then a ready-or-timeout
// stretch phase, then a single completing cycle.
module soc_bus_waitgen
  import soc_bus_fabric_pkg::*;
#(
  parameter int TIMEOUT = 64
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       req,
  input  logic [3:0] wait_cycles,
  input  logic       slot_ready,
  output logic       stall,
  output logic       complete,
  output logic       timed_out
);

  localparam int SW = $clog2(TIMEOUT + 1);
  localparam logic [SW-1:0] TO_LAST = SW'(TIMEOUT - 1);

  localparam logic [1:0] ST_IDLE    = FSM_IDLE;
  localparam logic [1:0] ST_WAIT    = FSM_WAIT;
  localparam logic [1:0] ST_STRETCH = FSM_STRETCH;
  localparam logic [1:0] ST_DONE    = FSM_DONE;

  logic [1:0]    state_q;
  logic [1:0]    state_d;
  logic [3:0]    wait_cnt;
  logic [SW-1:0] stretch_cnt;
  logic          to_q;
  logic          zero_wait;

  assign zero_wait = (wait_cycles == 4'd0) && slot_ready;
  assign timed_out = (state_q == ST_DONE) && to_q;

  // The decode (IDLE) cycle already counts as the first wait cycle.
  always_comb begin
    state_d  = state_q;
    stall    = 1'b0;
    complete = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req) begin
          if (zero_wait) begin
            complete = 1'b1;
          end else begin
            stall   = 1'b1;
            state_d = (wait_cycles > 4'd1) ? ST_WAIT : ST_STRETCH;
          end
        end
      end
      ST_WAIT: begin
        stall = req;
        if (!req) begin
          state_d = ST_IDLE;
        end else if (wait_cnt == 4'd1) begin
          state_d = ST_STRETCH;
        end
      end
      ST_STRETCH: begin
        stall = req;
        if (!req) begin
          state_d = ST_IDLE;
        end else if (slot_ready || (stretch_cnt == TO_LAST)) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        complete = 1'b1;
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      wait_cnt    <= 4'd0;
      stretch_cnt <= '0;
      to_q        <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        ST_IDLE: begin
          wait_cnt    <= (wait_cycles == 4'd0) ? 4'd0 : wait_cycles - 4'd1;
          stretch_cnt <= '0;
          to_q        <= 1'b0;
        end
        ST_WAIT: wait_cnt <= wait_cnt - 4'd1;
        ST_STRETCH: begin
          if (!slot_ready) begin
            if (stretch_cnt == TO_LAST) begin
              to_q <= 1'b1;
            end else begin
              stretch_cnt <= stretch_cnt + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/soc_bus_fabric.sv
// CPU bus fabric: RAM/ROM/IO address decode, peripheral slot handshaking with
// wait states and timeout, control-page registers and interrupt combining.
module soc_bus_fabric
  import soc_bus_fabric_pkg::*;
#(
  parameter int                 AW       = 16,
  parameter int                 NSLOT    = 4,
  parameter logic [AW-13:0]     IOPAGE   = 'hd,
  parameter logic [AW-13:0]     ROMPAGE1 = 'he,
  parameter logic [AW-13:0]     ROMPAGE2 = 'hf,
  parameter logic [4*NSLOT-1:0] WAIT_CFG = '0,
  parameter int                 TIMEOUT  = 64
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [AW-1:0]      cpu_ab,
  input  logic [7:0]         cpu_do,
  input  logic               cpu_we_n,
  output logic [7:0]         cpu_di,
  output logic               cpu_rdy,
  output logic               cpu_irq_n,
  input  logic               ext_irq_n,
  output logic               ram_we_n,
  input  logic [7:0]         ram_di,
  input  logic [7:0]         rom_di,
  output logic [NSLOT-1:0]   slot_cs_n,
  output logic               slot_we_n,
  input  logic [8*NSLOT-1:0] slot_di,
  input  logic [NSLOT-1:0]   slot_rdy,
  input  logic [NSLOT-1:0]   slot_irq_n
);

  localparam logic [5:0] NSLOT_W = 6'(NSLOT);

  logic [AW-13:0] page;
  logic [5:0]     sub_page;
  logic [5:0]     reg_off;
  logic [2:0]     slot_idx;
  logic           rom_hit;
  logic           io_hit;
  logic           ram_hit;
  logic           slot_hit;
  logic           ctrl_hit;
  logic           ctrl_wr;

  logic [3:0]     sel_wait;
  logic           sel_rdy;
  logic [7:0]     sel_di;

  logic           stall;
  logic           complete;
  logic           timed_out;

  src_e           src_d;
  src_e           src_q;
  logic [7:0]     slot_data_q;
  logic [7:0]     ctrl_q;
  logic [7:0]     ctrl_rd;
  logic [7:0]     status8;
  logic [7:0]     mask_q;
  logic           err_q;
  logic [2:0]     errslot_q;
  logic           irq_q;

  assign page     = cpu_ab[AW-1:12];
  assign sub_page = cpu_ab[11:6];
  assign reg_off  = cpu_ab[5:0];
  assign slot_idx = sub_page[2:0];

  assign rom_hit  = (page == ROMPAGE1) || (page == ROMPAGE2);
  assign io_hit   = !rom_hit && (page == IOPAGE);
  assign ram_hit  = !rom_hit && !io_hit;
  assign slot_hit = io_hit && (sub_page < NSLOT_W);
  assign ctrl_hit = io_hit && (sub_page == CTRL_SUBPAGE);
  assign ctrl_wr  = ctrl_hit && !cpu_we_n;

  always_comb begin
    sel_wait = 4'd0;
    sel_rdy  = 1'b0;
    sel_di   = UNMAPPED_RD;
    for (int k = 0; k < NSLOT; k++) begin
      if (slot_idx == 3'(k)) begin
        sel_wait = WAIT_CFG[4*k +: 4];
        sel_rdy  = slot_rdy[k];
        sel_di   = slot_di[8*k +: 8];
      end
    end
  end

  soc_bus_waitgen #(
    .TIMEOUT (TIMEOUT)
  ) u_waitgen (
    .clk         (clk),
    .reset_n     (reset_n),
    .req         (slot_hit),
    .wait_cycles (sel_wait),
    .slot_ready  (sel_rdy),
    .stall       (stall),
    .complete    (complete),
    .timed_out   (timed_out)
  );

  // Strobes and selects are forced inactive while reset is held so an
  // in-flight access cannot leak a write.
  assign cpu_rdy   = !reset_n || !stall;
  assign ram_we_n  = !(reset_n && ram_hit && !cpu_we_n);
  assign slot_we_n = !(reset_n && slot_hit && complete && !cpu_we_n);

  always_comb begin
    slot_cs_n = '1;
    for (int k = 0; k < NSLOT; k++) begin
      if (reset_n && slot_hit && (slot_idx == 3'(k))) begin
        slot_cs_n[k] = 1'b0;
      end
    end
  end

  always_comb begin
    status8              = 8'h00;
    status8[NSLOT-1:0]   = ~slot_irq_n;
    case (reg_off)
      REG_STATUS: ctrl_rd = status8;
      REG_MASK:   ctrl_rd = mask_q;
      REG_ERR:    ctrl_rd = err_reg_value(err_q, errslot_q);
      default:    ctrl_rd = UNMAPPED_RD;
    endcase
  end

  always_comb begin
    if (rom_hit)       src_d = SRC_ROM;
    else if (ram_hit)  src_d = SRC_RAM;
    else if (slot_hit) src_d = SRC_SLOT;
    else if (ctrl_hit) src_d = SRC_CTRL;
    else               src_d = SRC_UNMAPPED;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      src_q       <= SRC_UNMAPPED;
      slot_data_q <= UNMAPPED_RD;
      ctrl_q      <= UNMAPPED_RD;
    end else begin
      src_q       <= src_d;
      slot_data_q <= timed_out ? UNMAPPED_RD : sel_di;
      ctrl_q      <= ctrl_rd;
    end
  end

  // A timeout landing in the same cycle as an ERR write wins, so it is never lost.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      mask_q    <= 8'h00;
      err_q     <= 1'b0;
      errslot_q <= 3'd0;
    end else begin
      if (ctrl_wr && (reg_off == REG_MASK)) begin
        mask_q <= cpu_do;
      end
      if (ctrl_wr && (reg_off == REG_ERR)) begin
        err_q     <= 1'b0;
        errslot_q <= 3'd0;
      end
      if (slot_hit && complete && timed_out) begin
        err_q     <= 1'b1;
        errslot_q <= slot_idx;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      irq_q <= 1'b1;
    end else begin
      irq_q <= ext_irq_n && !(|(~slot_irq_n & mask_q[NSLOT-1:0]));
    end
  end

  assign cpu_irq_n = irq_q;

  always_comb begin
    case (src_q)
      SRC_RAM:  cpu_di = ram_di;
      SRC_ROM:  cpu_di = rom_di;
      SRC_SLOT: cpu_di = slot_data_q;
      SRC_CTRL: cpu_di = ctrl_q;
      default:  cpu_di = UNMAPPED_RD;
    endcase
  end

endmodule

// File: tb/tb_soc_bus_fabric.sv
// Directed bench for soc_bus_fabric: single-cycle access table plus
// hand-written wait, stretch, timeout, interrupt and reset sequences.
module tb_soc_bus_fabric;
  import soc_bus_fabric_pkg::*;

  localparam int          NS   = 4;
  localparam logic [15:0] PARK = 16'hD100;

  logic          clk;
  logic          reset_n;
  logic [15:0]   cpu_ab;
  logic [7:0]    cpu_do;
  logic          cpu_we_n;
  logic [7:0]    cpu_di;
  logic          cpu_rdy;
  logic          cpu_irq_n;
  logic          ext_irq_n;
  logic          ram_we_n;
  logic [7:0]    ram_di;
  logic [7:0]    rom_di;
  logic [NS-1:0] slot_cs_n;
  logic          slot_we_n;
  logic [8*NS-1:0] slot_di;
  logic [NS-1:0] slot_rdy;
  logic [NS-1:0] slot_irq_n;

  int compared = 0;
  int mismatched = 0;
  int swe_low_count = 0;

  typedef struct {
    logic [15:0] ab;
    logic        we_n;
    logic [7:0]  dout;
    logic        rdy;
    logic        ram_we_n;
    logic        swe_n;
    logic [3:0]  cs_n;
    logic        chk_di;
    logic [7:0]  di;
  } vec_t;

  vec_t vecs[18];

  soc_bus_fabric #(
    .AW       (16),
    .NSLOT    (NS),
    .WAIT_CFG (16'h0030),
    .TIMEOUT  (64)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .cpu_ab     (cpu_ab),
    .cpu_do     (cpu_do),
    .cpu_we_n   (cpu_we_n),
    .cpu_di     (cpu_di),
    .cpu_rdy    (cpu_rdy),
    .cpu_irq_n  (cpu_irq_n),
    .ext_irq_n  (ext_irq_n),
    .ram_we_n   (ram_we_n),
    .ram_di     (ram_di),
    .rom_di     (rom_di),
    .slot_cs_n  (slot_cs_n),
    .slot_we_n  (slot_we_n),
    .slot_di    (slot_di),
    .slot_rdy   (slot_rdy),
    .slot_irq_n (slot_irq_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous read-first RAM and a ROM whose contents are addr[7:0] ^ 8'hA5.
  logic [7:0] mem [0:4095];
  initial for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
  always @(posedge clk) begin
    if (!ram_we_n) mem[cpu_ab[11:0]] <= cpu_do;
    ram_di <= mem[cpu_ab[11:0]];
    rom_di <= cpu_ab[7:0] ^ 8'hA5;
  end

  always @(negedge clk) if (!slot_we_n) swe_low_count++;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic applyStimulus(input logic [15:0] ab, input logic we_n, input logic [7:0] dout);
    @(posedge clk);
    #1;
    cpu_ab   = ab;
    cpu_we_n = we_n;
    cpu_do   = dout;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  initial begin
    int rdy_low, cs_low, we_low, st_cnt, swe_base;
    logic done;

    //        ab        we_n  dout   rdy  ramwe swe  cs     chk  di
    vecs[0]  = '{16'h0200, 1'b0, 8'h5A, 1'b1, 1'b0, 1'b1, 4'hF, 1'b0, 8'h00};
    vecs[1]  = '{16'h0200, 1'b1, 8'h00, 1'b1, 1'b1, 1'b1, 4'hF, 1'b1, 8'h5A};
    vecs[2]  = '{16'h1234, 1'b0, 8'hC3, 1'b1, 1'b0, 1'b1, 4'hF, 1'b0, 8'h00};
    vecs[3]  = '{16'h1234, 1'b1, 8'h00, 1'b1, 1'b1, 1'b1, 4'hF, 1'b1, 8'hC3};
    vecs[4]  = '{16'hE012, 1'b1, 8'h00, 1'b1, 1'b1, 1'b1, 4'hF, 1'b1, 8'hB7};
    vecs[5]  = '{16'hF001, 1'b0, 8'h99, 1'b1, 1'b1, 1'b1, 4'hF, 1'b0, 8'h00};
    vecs[6]  = '{16'hF0FF, 1'b1, 8'h00, 1'b1, 1'b1, 1'b1, 4'hF, 1'b1, 8'h5A};
    vecs[7]  = '{16'hD100, 1'b1, 8'h00, 1'b1, 1'b1, 1'b1, 4'hF, 1'b1, 8'hFF};
    vecs[8]  = '{16'hD3C0, 1'b0, 8'h11, 1'b1, 1'b1, 1'b1, 4'hF, 1'b0, 8'h00};
    vecs[9]  = '{16'hD000, 1'b1, 8'h00, 1'b1, 1'b1, 1'b1, 4'hE, 1'b1, 8'h10};
    vecs[10] = '{16'hD0C0, 1'b1, 8'h00, 1'b1, 1'b1, 1'b1, 4'h7, 1'b1, 8'h13};
    vecs[11] = '{16'hD080, 1'b0, 8'h44, 1'b1, 1'b1, 1'b0, 4'hB, 1'b0, 8'h00};
    vecs[12] = '{16'hDFC0, 1'b1, 8'h00, 1'b1, 1'b1, 1'b1, 4'hF, 1'b1, 8'h00};
    vecs[13] = '{16'hDFC1, 1'b0, 8'h5A, 1'b1, 1'b1, 1'b1, 4'hF, 1'b0, 8'h00};
    vecs[14] = '{16'hDFC1, 1'b1, 8'h00, 1'b1, 1'b1, 1'b1, 4'hF, 1'b1, 8'h5A};
    vecs[15] = '{16'hDFC1, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 4'hF, 1'b0, 8'h00};
    vecs[16] = '{16'hDFC5, 1'b1, 8'h00, 1'b1, 1'b1, 1'b1, 4'hF, 1'b1, 8'hFF};
    vecs[17] = '{16'hDFC2, 1'b1, 8'h00, 1'b1, 1'b1, 1'b1, 4'hF, 1'b1, 8'h00};

    reset_n    = 1'b0;
    cpu_ab     = 16'hD000;
    cpu_we_n   = 1'b0;
    cpu_do     = 8'hEE;
    ext_irq_n  = 1'b1;
    slot_di    = {8'h13, 8'h12, 8'h11, 8'h10};
    slot_rdy   = 4'hF;
    slot_irq_n = 4'hF;

    // Reset state, with a slot write and then a RAM write held on the bus.
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("reset cpu_rdy", cpu_rdy, 1'b1);
    checkOutput("reset slot_cs_n", slot_cs_n, 4'hF);
    checkOutput("reset slot_we_n", slot_we_n, 1'b1);
    checkOutput("reset cpu_di", cpu_di, 8'hFF);
    checkOutput("reset cpu_irq_n", cpu_irq_n, 1'b1);
    cpu_ab = 16'h0300;
    #1;
    checkOutput("reset ram_we_n", ram_we_n, 1'b1);
    applyStimulus(PARK, 1'b1, 8'h00);
    reset_n = 1'b1;

    for (int i = 0; i < 18; i++) begin
      applyStimulus(vecs[i].ab, vecs[i].we_n, vecs[i].dout);
      @(negedge clk);
      checkOutput($sformatf("vec%0d cpu_rdy", i), cpu_rdy, vecs[i].rdy);
      checkOutput($sformatf("vec%0d ram_we_n", i), ram_we_n, vecs[i].ram_we_n);
      checkOutput($sformatf("vec%0d slot_we_n", i), slot_we_n, vecs[i].swe_n);
      checkOutput($sformatf("vec%0d slot_cs_n", i), slot_cs_n, vecs[i].cs_n);
      applyStimulus(PARK, 1'b1, 8'h00);
      @(negedge clk);
      if (vecs[i].chk_di) checkOutput($sformatf("vec%0d cpu_di", i), cpu_di, vecs[i].di);
    end

    // Slot 1 read with three wait cycles and ready already high.
    applyStimulus(16'hD040, 1'b1, 8'h00);
    rdy_low = 0; cs_low = 0; done = 1'b0;
    for (int c = 0; c < 20 && !done; c++) begin
      @(negedge clk);
      if (!cpu_rdy) rdy_low++;
      if (!slot_cs_n[1]) cs_low++;
      if (cpu_rdy) done = 1'b1;
    end
    checkOutput("slot1 completed", done, 1'b1);
    checkOutput("slot1 rdy low cycles", rdy_low, 4);
    checkOutput("slot1 cs low cycles", cs_low, 5);
    applyStimulus(PARK, 1'b1, 8'h00);
    @(negedge clk);
    checkOutput("slot1 read data", cpu_di, 8'h11);
    checkOutput("slot1 cs released", slot_cs_n, 4'hF);

    // Slot 2 write, ready rises late in the stretch phase.
    slot_rdy = 4'b1011;
    applyStimulus(16'hD080, 1'b0, 8'h77);
    rdy_low = 0; we_low = 0; done = 1'b0;
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge clk);
      if (!cpu_rdy) rdy_low++;
      if (!slot_we_n) we_low++;
      if (cpu_rdy) begin
        done = 1'b1;
        checkOutput("slot2 we at done", slot_we_n, 1'b0);
      end
      if (c == 9) slot_rdy[2] = 1'b1;
    end
    checkOutput("slot2 completed", done, 1'b1);
    checkOutput("slot2 rdy low cycles", rdy_low, 10);
    checkOutput("slot2 write pulses", we_low, 1);
    applyStimulus(PARK, 1'b1, 8'h00);
    slot_rdy = 4'hF;

    // Slot 0 read with ready stuck low: timeout, error register, clear.
    slot_rdy = 4'b1110;
    applyStimulus(16'hD000, 1'b1, 8'h00);
    rdy_low = 0; st_cnt = 0; done = 1'b0;
    for (int c = 0; c < 200 && !done; c++) begin
      @(negedge clk);
      if (!cpu_rdy) rdy_low++;
      if (dut.u_waitgen.state_q == FSM_STRETCH) st_cnt++;
      if (cpu_rdy) done = 1'b1;
    end
    checkOutput("timeout completed", done, 1'b1);
    checkOutput("timeout stretch cycles", st_cnt, 64);
    checkOutput("timeout rdy low cycles", rdy_low, 65);
    applyStimulus(PARK, 1'b1, 8'h00);
    @(negedge clk);
    checkOutput("timeout read data", cpu_di, 8'hFF);
    slot_rdy = 4'hF;
    applyStimulus(16'hDFC2, 1'b1, 8'h00);
    applyStimulus(PARK, 1'b1, 8'h00);
    @(negedge clk);
    checkOutput("err reg after timeout", cpu_di, 8'h80);
    applyStimulus(16'hDFC2, 1'b0, 8'h00);
    applyStimulus(16'hDFC2, 1'b1, 8'h00);
    applyStimulus(PARK, 1'b1, 8'h00);
    @(negedge clk);
    checkOutput("err reg after clear", cpu_di, 8'h00);

    // MASK write and slot 1 interrupt arriving in the same cycle.
    @(negedge clk);
    checkOutput("irq idle", cpu_irq_n, 1'b1);
    applyStimulus(16'hDFC1, 1'b0, 8'h02);
    slot_irq_n = 4'b1101;
    @(negedge clk);
    checkOutput("irq same cycle", cpu_irq_n, 1'b1);
    applyStimulus(PARK, 1'b1, 8'h00);
    @(negedge clk);
    checkOutput("irq old mask applies", cpu_irq_n, 1'b1);
    applyStimulus(PARK, 1'b1, 8'h00);
    @(negedge clk);
    checkOutput("irq masked slot1 asserted", cpu_irq_n, 1'b0);
    applyStimulus(16'hDFC0, 1'b1, 8'h00);
    applyStimulus(PARK, 1'b1, 8'h00);
    @(negedge clk);
    checkOutput("status reg", cpu_di, 8'h02);
    applyStimulus(16'hDFC1, 1'b0, 8'h00);
    applyStimulus(PARK, 1'b1, 8'h00);
    applyStimulus(PARK, 1'b1, 8'h00);
    @(negedge clk);
    checkOutput("irq mask cleared", cpu_irq_n, 1'b1);
    applyStimulus(PARK, 1'b1, 8'h00);
    ext_irq_n = 1'b0;
    applyStimulus(PARK, 1'b1, 8'h00);
    @(negedge clk);
    checkOutput("irq external", cpu_irq_n, 1'b0);
    ext_irq_n  = 1'b1;
    slot_irq_n = 4'hF;

    // Reset pulsed during the WAIT phase of a slot 1 write.
    swe_base = swe_low_count;
    applyStimulus(16'hD040, 1'b0, 8'h66);
    @(negedge clk);
    checkOutput("abort stall before reset", cpu_rdy, 1'b0);
    applyStimulus(16'hD040, 1'b0, 8'h66);
    @(negedge clk);
    checkOutput("abort in wait", dut.u_waitgen.state_q, FSM_WAIT);
    @(posedge clk);
    #1;
    reset_n = 1'b0;
    @(negedge clk);
    checkOutput("abort rdy in reset", cpu_rdy, 1'b1);
    checkOutput("abort cs in reset", slot_cs_n, 4'hF);
    applyStimulus(PARK, 1'b1, 8'h00);
    @(negedge clk);
    checkOutput("abort fsm idle", dut.u_waitgen.state_q, FSM_IDLE);
    checkOutput("abort cpu_di", cpu_di, 8'hFF);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    applyStimulus(PARK, 1'b1, 8'h00);
    @(negedge clk);
    checkOutput("abort no write", swe_low_count - swe_base, 0);
    applyStimulus(16'hD000, 1'b1, 8'h00);
    @(negedge clk);
    checkOutput("post reset slot0 rdy", cpu_rdy, 1'b1);
    applyStimulus(PARK, 1'b1, 8'h00);
    @(negedge clk);
    checkOutput("post reset slot0 data", cpu_di, 8'h10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
